// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: fetch state encoding, PC source selects and
// small sizing helpers used by the control sequencer and the datapath.
package slc3_pkg;

  // Control states; the encoding is visible on the debug LEDs.
  typedef enum logic [3:0] {
    HALTED = 4'd0,
    S_18   = 4'd1,
    S_33   = 4'd2,
    S_35   = 4'd3,
    PAUSE  = 4'd4
  } fetch_state_t;

  // PC source selects for the datapath PC mux.
  localparam logic [1:0] PC_PLUS1 = 2'b00;
  localparam logic [1:0] PC_BUS   = 2'b01;
  localparam logic [1:0] PC_ADDER = 2'b10;

  // Width of a counter that must hold the values 0..mem_wait.
  function automatic int wait_cnt_width(input int mem_wait);
    return $clog2(mem_wait + 1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already-synchronised level input.
// The pulse is high for the one cycle in which the level is 1 and the
// previously sampled level was 0, so a held button yields one pulse.
module edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic level,
  output logic rise
);

  logic prev_q;

  // Remember last cycle's level; cleared by the synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    if (!Reset) prev_q <= 1'b0;
    else        prev_q <= level;
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-only SLC-3 control sequencer. Walks MAR<-PC / PC<-PC+1 (S_18),
// MDR<-M[MAR] with a stretched SRAM read (S_33), IR<-MDR (S_35), then
// parks in PAUSE until the operator presses Continue. Outputs decode only
// from the state register and the wait counter; the button edges affect
// the next state alone.
module fetch_ctrl
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2  // cycles Mem_OE is held low per read, 1..15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  output logic        LD_MAR,
  output logic        LD_PC,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        GatePC,
  output logic        GateMDR,
  output logic [1:0]  PCMUX,
  output logic        Mem_OE,
  output logic        Mem_WE,
  output logic [3:0]  state_o,
  output logic [15:0] fetch_count
);

  localparam int              CW        = wait_cnt_width(MEM_WAIT);
  localparam logic [CW-1:0]   WAIT_LAST = CW'(MEM_WAIT - 1);

  fetch_state_t  state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [15:0]   fetch_cnt_q;
  logic          run_rise, cont_rise;

  edge_detect u_run_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .level (Run),
    .rise  (run_rise)
  );

  edge_detect u_cont_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .level (Continue),
    .rise  (cont_rise)
  );

  // State, wait counter and completed-fetch counter registers.
  always_ff @(posedge Clk) begin
    // NOTE: reset is sampled on the clock edge only; an aborted fetch leaves
    // no trace because every register returns to its reset value together.
    if (!Reset) begin
      state_q     <= HALTED;
      wait_q      <= '0;
      fetch_cnt_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_35) fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end

  // Next-state and wait-counter logic; button edges outside their own
  // waiting state are simply not looked at, so they are dropped.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred.
    state_d = state_q;
    wait_d  = '0;
    unique case (state_q)
      HALTED: if (run_rise) state_d = S_18;
      S_18:   state_d = S_33;
      S_33: begin
        if (wait_q == WAIT_LAST) state_d = S_35;
        else                     wait_d  = wait_q + 1'b1;
      end
      S_35:   state_d = PAUSE;
      PAUSE:  if (cont_rise) state_d = S_18;
      default: state_d = HALTED;
    endcase
  end

  // Strobe decode from the registered state and wait counter.
  always_comb begin
    LD_MAR  = 1'b0;
    LD_PC   = 1'b0;
    LD_MDR  = 1'b0;
    LD_IR   = 1'b0;
    GatePC  = 1'b0;
    GateMDR = 1'b0;
    Mem_OE  = 1'b1;
    unique case (state_q)
      S_18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
      end
      S_33: begin
        Mem_OE = 1'b0;
        LD_MDR = (wait_q == WAIT_LAST);
      end
      S_35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCMUX       = PC_PLUS1;
  assign Mem_WE      = 1'b1;
  assign state_o     = state_q;
  assign fetch_count = fetch_cnt_q;

endmodule
